yarp_data_mem: RTL

Load/store stage of the YARP RV32I core, directly downstream of the ALU. It takes the ALU result as the effective address and issues one memory transaction per LB/LH/LW/LBU/LHU/SB/SH/SW over a request/grant/response bus. It performs byte-lane steering, byte-enable generation, load sign/zero extension and misalignment handling. It stalls the pipeline until the transaction completes.

---
 rtl/yarp_pkg.sv | 17 +
 rtl/yarp_lsu_align.sv | 55 +++++
 rtl/yarp_data_mem.sv | 132 +++++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the YARP load/store stage: access-size encodings and LSU FSM states.
// Latency: n/a. Backpressure: n/a.
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/yarp_lsu_align.sv
// Byte-lane steering: byte enables, store replication, load shift/extend, misalign detect.
// Latency: purely combinational. Backpressure: none.
module yarp_lsu_align
    import yarp_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_zero_extnd,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_rd_data,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_rd_data,
    output logic        o_misalign
);

    logic [1:0]  w_lo;
    logic [31:0] w_shifted;

    always_comb begin
        w_lo       = i_addr_lo;
        o_byte_en  = 4'b1111;
        o_wr_data  = i_wr_data;
        o_rd_data  = 32'h0;
        o_misalign = 1'b0;
        // Low address bits a size cannot use are dropped, so a misaligned access stays in its own word.
        case (i_size)
            BYTE: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wr_data = {4{i_wr_data[7:0]}};
            end
            HALF_WORD: begin
                w_lo       = {i_addr_lo[1], 1'b0};
                o_byte_en  = 4'b0011 << w_lo;
                o_wr_data  = {2{i_wr_data[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            default: begin
                w_lo       = 2'b00;
                o_misalign = |i_addr_lo;
            end
        endcase

        w_shifted = i_rd_data >> {w_lo, 3'b000};

        case (i_size)
            BYTE:      o_rd_data = i_zero_extnd ? {24'h0, w_shifted[7:0]}
                                                : {{24{w_shifted[7]}}, w_shifted[7:0]};
            HALF_WORD: o_rd_data = i_zero_extnd ? {16'h0, w_shifted[15:0]}
                                                : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:   o_rd_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/yarp_data_mem.sv
// YARP load/store stage: one req/gnt/rvalid memory transaction per load/store; YARP_MISALIGN_TRAP_EN traps misaligned ops.
// Latency: store done 2 cycles after request (immediate gnt), load done 1 cycle after rvalid.
// Backpressure: lsu_busy_o stalls the pipeline until the one-cycle lsu_done_o pulse.
module yarp_data_mem
    import yarp_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_req_i,
    input  logic [31:0] ex_addr_i,
    input  logic        ex_wr_i,
    input  logic [1:0]  ex_size_i,
    input  logic        ex_zero_extnd_i,
    input  logic [31:0] ex_wr_data_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rd_data_o,
    output logic        lsu_misalign_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [3:0]  mem_byte_en_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rd_data_i
);

`ifdef YARP_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_t  r_state, w_next;
    logic        r_done, r_mis, r_wr, r_zext;
    logic [1:0]  r_size, r_addr_lo;
    logic [31:0] r_addr, r_wdata, r_rd;
    logic [3:0]  r_be;

    logic        w_idle, w_accept, w_trap, w_mis, w_zext;
    logic [1:0]  w_size, w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_rd;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle & ex_req_i & ~r_done;
    assign w_trap   = TRAP_EN & w_accept & w_mis;

    // Live operands while accepting; registered copies afterwards for load extension.
    assign w_size = w_idle ? ex_size_i       : r_size;
    assign w_lo   = w_idle ? ex_addr_i[1:0]  : r_addr_lo;
    assign w_zext = w_idle ? ex_zero_extnd_i : r_zext;

    yarp_lsu_align u_align (
        .i_size       (w_size),
        .i_addr_lo    (w_lo),
        .i_zero_extnd (w_zext),
        .i_wr_data    (ex_wr_data_i),
        .i_rd_data    (mem_rd_data_i),
        .o_byte_en    (w_be),
        .o_wr_data    (w_wdata),
        .o_rd_data    (w_rd),
        .o_misalign   (w_mis)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_trap) w_next = REQ;
            REQ:     if (mem_gnt_i)           w_next = r_wr ? IDLE : RESP;
            RESP:    if (mem_rvalid_i)        w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o  = (r_state == REQ);
        lsu_busy_o = ex_req_i & ~r_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done    <= 1'b0;
            r_mis     <= 1'b0;
            r_wr      <= 1'b0;
            r_zext    <= 1'b0;
            r_size    <= 2'b00;
            r_addr_lo <= 2'b00;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_be      <= 4'h0;
            r_rd      <= 32'h0;
        end else begin
            r_done <= 1'b0;
            r_mis  <= 1'b0;
            if (w_accept) begin
                if (w_trap) begin
                    r_done <= 1'b1;
                    r_mis  <= 1'b1;
                end else begin
                    r_addr    <= {ex_addr_i[31:2], 2'b00};
                    r_wr      <= ex_wr_i;
                    r_be      <= w_be;
                    r_wdata   <= w_wdata;
                    r_size    <= ex_size_i;
                    r_addr_lo <= ex_addr_i[1:0];
                    r_zext    <= ex_zero_extnd_i;
                end
            end
            if (r_state == REQ && mem_gnt_i && r_wr) r_done <= 1'b1;
            if (r_state == RESP && mem_rvalid_i) begin
                r_done <= 1'b1;
                r_rd   <= w_rd;
            end
        end
    end

    assign lsu_done_o     = r_done;
    assign lsu_misalign_o = r_mis;
    assign lsu_rd_data_o  = r_rd;
    assign mem_addr_o     = r_addr;
    assign mem_wr_o       = r_wr;
    assign mem_byte_en_o  = r_be;
    assign mem_wr_data_o  = r_wdata;

endmodule
